// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: per-channel ratio reload at period
// boundaries, graceful stop, tick pulse and global sync. Define CLKDIV_DUTY_EN
// to make the high time programmable through high_count.
`timescale 1ns/1ps
module clock_divider_multi #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 28
) (
  input  logic                      clock_in,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS*WIDTH-1:0] divide,
  input  logic [CHANNELS*WIDTH-1:0] high_count,
  input  logic [CHANNELS-1:0]       load,
  input  logic                      sync,
  output logic [CHANNELS-1:0]       clock_out,
  output logic [CHANNELS-1:0]       tick
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

`ifndef CLKDIV_DUTY_EN
  logic unused_high_count;
  assign unused_high_count = ^high_count;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t           state;
    logic [WIDTH-1:0] d_act, h_act, d_pend, h_pend, cnt;
    logic             pend, clk_q, tick_q;

    logic [WIDTH-1:0] d_ld, h_ld, d_new, h_new, h_next, cnt_inc;
    logic             have_new, wrap;

    // A load in the same cycle as an apply point bypasses the pending registers.
    always_comb begin
      d_ld = (divide[i*WIDTH +: WIDTH] == '0) ? WIDTH'(1) : divide[i*WIDTH +: WIDTH];
`ifdef CLKDIV_DUTY_EN
      h_ld = high_count[i*WIDTH +: WIDTH];
`else
      h_ld = d_ld >> 1;
`endif
      have_new = load[i] | pend;
      d_new    = load[i] ? d_ld : d_pend;
      h_new    = load[i] ? h_ld : h_pend;
      h_next   = have_new ? h_new : h_act;
      wrap     = (cnt == d_act - WIDTH'(1));
      cnt_inc  = cnt + WIDTH'(1);
    end

    // NOTE: non-blocking assignments throughout; within one edge a later
    // assignment to the same register (pend set by load, cleared by apply) wins.
    always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
        state  <= IDLE;
        cnt    <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        pend   <= 1'b0;
        d_act  <= WIDTH'(1);
        d_pend <= WIDTH'(1);
        h_act  <= '0;
        h_pend <= '0;
      end else begin
        if (load[i]) begin
          d_pend <= d_ld;
          h_pend <= h_ld;
          pend   <= 1'b1;
        end
        case (state)
          IDLE: begin
            if (have_new) begin
              d_act <= d_new;
              h_act <= h_new;
              pend  <= 1'b0;
            end
            if (enable[i]) begin
              state  <= RUN;
              cnt    <= '0;
              clk_q  <= (h_next != '0);
              tick_q <= 1'b1;
            end
          end
          RUN, STOPPING: begin
            // Completing a stop takes priority over a coincident sync.
            if (state == STOPPING && !enable[i] && wrap) begin
              state  <= IDLE;
              cnt    <= '0;
              clk_q  <= 1'b0;
              tick_q <= 1'b0;
              if (have_new) begin
                d_act <= d_new;
                h_act <= h_new;
                pend  <= 1'b0;
              end
            end else begin
              state <= enable[i] ? RUN : STOPPING;
              if (sync || wrap) begin
                if (have_new) begin
                  d_act <= d_new;
                  h_act <= h_new;
                  pend  <= 1'b0;
                end
                cnt    <= '0;
                clk_q  <= (h_next != '0);
                tick_q <= 1'b1;
              end else begin
                cnt    <= cnt_inc;
                clk_q  <= (cnt_inc < h_act);
                tick_q <= 1'b0;
              end
            end
          end
          default: begin
            state  <= IDLE;
            cnt    <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
          end
        endcase
      end
    end

    assign clock_out[i] = clk_q;
    assign tick[i]      = tick_q;
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Self-checking bench for clock_divider_multi: directed test-plan steps, then
// randomized traffic, checked against a period/phase reference model.
`timescale 1ns/1ps
module tb_clock_divider_multi;
  localparam int CH = 4;
  localparam int W  = 28;

  logic              clock_in, reset_n, sync;
  logic [CH-1:0]     enable, load, clock_out, tick;
  logic [CH*W-1:0]   divide, high_count;
  logic [W-1:0]      div_v [CH];
  logic [W-1:0]      hc_v  [CH];

  int n_vec = 0;
  int n_err = 0;

  // Reference model: whether a channel produces output, whether it is winding
  // down, the active and pending period/high time, and the phase in the period.
  bit m_on [CH], m_fin [CH], m_pv [CH];
  int m_per [CH], m_hi [CH], m_pper [CH], m_phi [CH], m_phase [CH];

  clock_divider_multi #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .enable    (enable),
    .divide    (divide),
    .high_count(high_count),
    .load      (load),
    .sync      (sync),
    .clock_out (clock_out),
    .tick      (tick)
  );

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      divide[i*W +: W]     = div_v[i];
      high_count[i*W +: W] = hc_v[i];
    end
  end

  initial begin
    clock_in = 1'b0;
    forever #5 clock_in = ~clock_in;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_on[i] = 0; m_fin[i] = 0; m_pv[i] = 0;
      m_per[i] = 1; m_pper[i] = 1; m_hi[i] = 0; m_phi[i] = 0; m_phase[i] = 0;
    end
  endtask

  function automatic int high_of(input int ch);
    int d;
    d = (div_v[ch] == 0) ? 1 : int'(div_v[ch]);
`ifdef CLKDIV_DUTY_EN
    return int'(hc_v[ch]);
`else
    return d / 2;
`endif
  endfunction

  task automatic model_edge(input int i);
    int  nd, nh;
    bit  avail, bnd;
    nd    = load[i] ? ((div_v[i] == 0) ? 1 : int'(div_v[i])) : m_pper[i];
    nh    = load[i] ? high_of(i) : m_phi[i];
    avail = load[i] || m_pv[i];
    if (load[i]) begin m_pper[i] = nd; m_phi[i] = nh; m_pv[i] = 1; end
    if (!m_on[i]) begin
      if (avail) begin m_per[i] = nd; m_hi[i] = nh; m_pv[i] = 0; end
      if (enable[i]) begin m_on[i] = 1; m_fin[i] = 0; m_phase[i] = 0; end
    end else begin
      bnd = (m_phase[i] == m_per[i] - 1);
      if (m_fin[i] && !enable[i] && bnd) begin
        m_on[i] = 0; m_phase[i] = 0;
        if (avail) begin m_per[i] = nd; m_hi[i] = nh; m_pv[i] = 0; end
      end else begin
        m_fin[i] = !enable[i];
        if (sync || bnd) begin
          if (avail) begin m_per[i] = nd; m_hi[i] = nh; m_pv[i] = 0; end
          m_phase[i] = 0;
        end else begin
          m_phase[i]++;
        end
      end
    end
  endtask

  task automatic step();
    logic [CH-1:0] exp_c, exp_t;
    for (int i = 0; i < CH; i++) model_edge(i);
    @(posedge clock_in);
    #1;
    for (int i = 0; i < CH; i++) begin
      exp_c[i] = m_on[i] && (m_phase[i] < m_hi[i]);
      exp_t[i] = m_on[i] && (m_phase[i] == 0);
    end
    check("clock_out", 32'(clock_out), 32'(exp_c));
    check("tick", 32'(tick), 32'(exp_t));
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic load_ch(input int ch, input int d, input int h);
    div_v[ch] = W'(d);
    hc_v[ch]  = W'(h);
    load[ch]  = 1'b1;
    step();
    load[ch]  = 1'b0;
  endtask

  task automatic wait_phase(input int ch, input int ph);
    bit found = 0;
    for (int k = 0; k < 200; k++) begin
      if (m_on[ch] && m_phase[ch] == ph) begin found = 1; break; end
      step();
    end
    check("wait_phase_timeout", 32'(found), 32'd1);
  endtask

  initial begin
    int hi_cnt, tk_cnt;
    reset_n = 1'b0; sync = 1'b0; enable = '0; load = '0;
    for (int i = 0; i < CH; i++) begin div_v[i] = '0; hc_v[i] = '0; end
    model_reset();
    repeat (2) @(posedge clock_in);
    #1;
    check("reset_clock_out", 32'(clock_out), 32'd0);
    check("reset_tick", 32'(tick), 32'd0);
    reset_n = 1'b1;

    // D=10 on ch0: 5 high / 5 low, one tick per period.
    load_ch(0, 10, 5);
    enable[0] = 1'b1;
    step();
    hi_cnt = 0; tk_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      hi_cnt += int'(clock_out[0]);
      tk_cnt += int'(tick[0]);
      step();
    end
    check("d10_high_cycles", 32'(hi_cnt), 32'd5);
    check("d10_ticks", 32'(tk_cnt), 32'd1);
    steps(12);

    // Reload to D=4 at cnt=3: current period completes first.
    wait_phase(0, 3);
    load_ch(0, 4, 2);
    steps(20);

    // Ch1 D=6 and ch2 D=9 out of phase, then sync.
    div_v[1] = W'(6); hc_v[1] = W'(3);
    div_v[2] = W'(9); hc_v[2] = W'(4);
    load = 4'b0110;
    step();
    load = '0;
    enable[1] = 1'b1;
    steps(2);
    enable[2] = 1'b1;
    steps(3);
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_tick", 32'(tick & 4'b0110), 32'h6);
    check("sync_clock_out", 32'(clock_out & 4'b0110), 32'h6);
    steps(20);

    // Ch0 D=8: stop at cnt=2, re-enable while stopping, then stop for good.
    load_ch(0, 8, 4);
    wait_phase(0, 7);
    wait_phase(0, 2);
    enable[0] = 1'b0;
    steps(4);
    enable[0] = 1'b1;
    steps(10);
    enable[0] = 1'b0;
    steps(20);
    check("stopped_clock_out0", 32'(clock_out[0]), 32'd0);
    check("stopped_tick0", 32'(tick[0]), 32'd0);

    // D=0 and D=1 on ch3: tick constantly high, clock_out low.
    load_ch(3, 0, 0);
    enable[3] = 1'b1;
    steps(5);
    check("d0_tick", 32'(tick[3]), 32'd1);
    check("d0_clock_out", 32'(clock_out[3]), 32'd0);
    load_ch(3, 1, 0);
    steps(3);
    check("d1_tick", 32'(tick[3]), 32'd1);
    check("d1_clock_out", 32'(clock_out[3]), 32'd0);
`ifdef CLKDIV_DUTY_EN
    load_ch(3, 5, 1);
    steps(6);
    hi_cnt = 0;
    for (int k = 0; k < 5; k++) begin hi_cnt += int'(clock_out[3]); step(); end
    check("d5_h1_high", 32'(hi_cnt), 32'd1);
    load_ch(3, 5, 7);
    steps(6);
    hi_cnt = 0;
    for (int k = 0; k < 5; k++) begin hi_cnt += int'(clock_out[3]); step(); end
    check("d5_h7_high", 32'(hi_cnt), 32'd5);
`endif

    // Randomized traffic on all channels.
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 19) == 0) enable[i] = ~enable[i];
        load[i] = ($urandom_range(0, 24) == 0);
        if (load[i]) begin
          div_v[i] = W'($urandom_range(0, 12));
          hc_v[i]  = W'($urandom_range(0, 14));
        end
      end
      sync = ($urandom_range(0, 39) == 0);
      step();
    end
    load = '0; sync = 1'b0; enable = 4'b0001;

    // Asynchronous reset in the middle of a high phase.
    load_ch(0, 10, 5);
    wait_phase(0, 7);
    wait_phase(0, 2);
    check("pre_reset_high", 32'(clock_out[0]), 32'd1);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_reset_clock_out", 32'(clock_out), 32'd0);
    check("async_reset_tick", 32'(tick), 32'd0);
    #2;
    reset_n = 1'b1;
    enable = '0;
    steps(3);
    enable[0] = 1'b1;
    steps(4);
    check("post_reset_d1_tick", 32'(tick[0]), 32'd1);
    check("post_reset_d1_clock_out", 32'(clock_out[0]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
